bus_arbiter_rr: RTL

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arb_pkg.sv | 18 +
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and index-width helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: none; winner is 0 when no request is asserted.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MST = 4,
    localparam int IDX_W   = idx_w(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   winner
);

    int               pos;
    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the request vector from start, wrapping at NUM_MST; keep the first hit.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_MST) pos = pos - NUM_MST;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Multi-master to single memory port arbiter (round-robin or fixed priority); optional WAIT timeout via BUS_ARB_TIMEOUT_EN.
// Latency: request seen in IDLE -> ISSUE next cycle -> read_req/write_req pulse the cycle after; ack same cycle as completion.
// Backpressure: masters hold request levels until acked; one transaction outstanding, others wait in IDLE arbitration.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MST   = 4,
    parameter  int ADR_W     = 32,
    parameter  int PRIO_MODE = 0,
    parameter  int TMO_CYC   = 1023,
    localparam int IDX_W     = idx_w(NUM_MST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MST-1:0]       m_read_req,
    input  logic [NUM_MST-1:0]       m_write_req,
    input  logic [NUM_MST-1:0]       m_w,
    input  logic [NUM_MST-1:0]       m_hw,
    input  logic [NUM_MST*ADR_W-1:0] m_adr,
    input  logic [NUM_MST*32-1:0]    m_wdata,
    output logic                     read_req,
    output logic                     write_req,
    output logic                     read_w,
    output logic                     read_hw,
    output logic                     write_w,
    output logic                     write_hw,
    output logic [ADR_W-1:0]         read_adr,
    output logic [ADR_W-1:0]         write_adr,
    output logic [31:0]              write_data,
    input  logic                     read_valid,
    input  logic                     write_finish,
    output logic [NUM_MST-1:0]       m_read_valid,
    output logic [NUM_MST-1:0]       m_write_finish,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    output logic                     tmo_err
`endif
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last_owner, rr_next, start_idx, winner;
    logic [NUM_MST-1:0] req_vec;
    logic             any_req, win_wr, cur_wr, cmpl_hit, tmo_hit, done_hit;
    logic [ADR_W-1:0] adr_arr  [NUM_MST];
    logic [31:0]      wdat_arr [NUM_MST];

    for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
        assign adr_arr[g]  = m_adr[g*ADR_W +: ADR_W];
        assign wdat_arr[g] = m_wdata[g*32 +: 32];
    end

    assign req_vec   = m_read_req | m_write_req;
    assign any_req   = |req_vec;
    // Write beats read when one master raises both.
    assign win_wr    = m_write_req[winner];
    assign rr_next   = (last_owner == IDX_W'(NUM_MST - 1)) ? '0 : last_owner + 1'b1;
    assign start_idx = (PRIO_MODE != 0) ? '0 : rr_next;

    rr_pick #(.NUM_MST(NUM_MST)) u_pick (
        .req    (req_vec),
        .start  (start_idx),
        .winner (winner)
    );

    // Only the completion type matching the owned command counts.
    assign cmpl_hit = cur_wr ? write_finish : read_valid;
    assign done_hit = (state == ST_WAIT) && (cmpl_hit || tmo_hit);
    assign busy     = (state != ST_IDLE);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign tmo_hit = (state == ST_WAIT) && !cmpl_hit && (wait_cnt == CNT_W'(TMO_CYC - 1));

    // Count cycles spent in WAIT; flag a sticky error when the limit forces completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            tmo_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
            if (tmo_hit) tmo_err <= 1'b1;
        end
    end
`else
    // Never fires: WAIT is unbounded in this build.
    assign tmo_hit = (TMO_CYC < 0);
`endif

    // Route the completion pulse to the current owner only.
    always_comb begin
        m_read_valid   = '0;
        m_write_finish = '0;
        if (done_hit) begin
            if (cur_wr) m_write_finish[owner] = 1'b1;
            else        m_read_valid[owner]   = 1'b1;
        end
    end

    // Next-state decode for IDLE -> ISSUE -> WAIT -> DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register, grant capture and single-cycle memory request pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_MST - 1);
            cur_wr     <= 1'b0;
            read_req   <= 1'b0;
            write_req  <= 1'b0;
            read_w     <= 1'b0;
            read_hw    <= 1'b0;
            write_w    <= 1'b0;
            write_hw   <= 1'b0;
            read_adr   <= '0;
            write_adr  <= '0;
            write_data <= '0;
        end else begin
            state     <= state_nxt;
            read_req  <= (state == ST_ISSUE) && !cur_wr;
            write_req <= (state == ST_ISSUE) && cur_wr;
            if (state == ST_IDLE && any_req) begin
                owner      <= winner;
                last_owner <= winner;
                cur_wr     <= win_wr;
                if (win_wr) begin
                    write_adr  <= adr_arr[winner];
                    write_data <= wdat_arr[winner];
                    write_w    <= m_w[winner];
                    write_hw   <= m_hw[winner];
                end else begin
                    read_adr   <= adr_arr[winner];
                    read_w     <= m_w[winner];
                    read_hw    <= m_hw[winner];
                end
            end
        end
    end

endmodule
